// File: rtl/data_memory_responder_if.sv
// CPU data-memory bus between the MEM stage (master) and the memory responder (slave).
interface data_memory_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, addr, wdata, input busy, ack, rdata, err);
   modport slave  (input req, we, addr, wdata, output busy, ack, rdata, err);
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering one load/store at a time after a fixed latency,
// stalling the pipeline via busy until the single-cycle ack.
module data_memory_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   data_memory_responder_if.slave bus
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               errl_q, errl_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               mem_we_c;
   logic               req_err_c;

   logic [31:0] mem [DEPTH_WORDS];

   assign req_err_c = (bus.addr[1:0] != 2'b00) ||
                      ({2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         errl_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         errl_q  <= errl_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is deliberately not reset; a write only happens on the commit edge.
   always_ff @(posedge clk_i) begin
      if (mem_we_c) begin
         mem[idx_q] <= wdata_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      errl_d   = errl_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      mem_we_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               idx_d   = bus.addr[IDX_W+1:2];
               wdata_d = bus.wdata;
               errl_d  = req_err_c;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               ack_d   = 1'b1;
               err_d   = errl_q;
               state_d = RESP;
               if (errl_q) begin
                  rdata_d = '0;
               end else if (we_q) begin
                  mem_we_c = 1'b1;
               end else begin
                  rdata_d = mem[idx_q];
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // busy is combinational so the stall reaches the hazard logic in the request cycle.
   assign bus.busy  = ((state_q == IDLE) && bus.req) || (state_q == WAIT);
   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder with default parameters
// (DEPTH_WORDS=256, LATENCY=3).
module tb_data_memory_responder;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] last_rd;
   logic        last_err;
   int          last_lat;

   data_memory_responder_if bus ();

   data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One full request/response; leaves req low and ack already returned to 0.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
      int  n;
      logic got;
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      #1;
      chk("busy_req_cycle", 32'(bus.busy), 32'd1);
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.ack) got = 1'b1;
         else chk("busy_wait", 32'(bus.busy), 32'd1);
      end
      if (!got) chk("ack_timeout", 32'(bus.ack), 32'd1);
      last_lat = n - 1;
      last_rd  = bus.rdata;
      last_err = bus.err;
      chk("busy_ack_cycle", 32'(bus.busy), 32'd0);
      bus.req = 1'b0;
      @(negedge clk);
      chk("ack_one_cycle", {30'd0, bus.ack, bus.err}, 32'd0);
   endtask

   initial begin
      int n;
      int first_ack;
      int second_ack;
      rst       = 1'b1;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_ack",   32'(bus.ack),  32'd0);
      chk("rst_err",   32'(bus.err),  32'd0);
      chk("rst_rdata", bus.rdata,     32'd0);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      rst = 1'b0;

      // Seed mem[4], then read it back with latency checks
      access(1'b1, 32'h10, 32'h1111_1111);
      chk("st10_lat",   32'(last_lat), 32'd3);
      chk("st10_err",   32'(last_err), 32'd0);
      chk("st10_rdata", last_rd,       32'd0);
      access(1'b0, 32'h10, 32'h0);
      chk("ld10_lat",  32'(last_lat), 32'd3);
      chk("ld10_data", last_rd,       32'h1111_1111);
      chk("ld10_err",  32'(last_err), 32'd0);

      // Store then load; store ack leaves data_o alone
      access(1'b1, 32'h20, 32'hDEAD_BEEF);
      chk("st20_rdata", last_rd,       32'h1111_1111);
      chk("st20_err",   32'(last_err), 32'd0);
      access(1'b0, 32'h20, 32'h0);
      chk("ld20_data", last_rd,       32'hDEAD_BEEF);
      chk("ld20_err",  32'(last_err), 32'd0);

      // Misaligned store must not touch the word at 0x20
      access(1'b1, 32'h22, 32'h1234_5678);
      chk("mis_lat",   32'(last_lat), 32'd3);
      chk("mis_err",   32'(last_err), 32'd1);
      chk("mis_rdata", last_rd,       32'd0);
      access(1'b0, 32'h20, 32'h0);
      chk("ld20_after_mis", last_rd, 32'hDEAD_BEEF);

      // Address range boundaries
      access(1'b1, 32'h3FC, 32'hCAFE_F00D);
      chk("st3fc_err", 32'(last_err), 32'd0);
      access(1'b0, 32'h3FC, 32'h0);
      chk("ld3fc_data", last_rd,       32'hCAFE_F00D);
      chk("ld3fc_err",  32'(last_err), 32'd0);
      access(1'b0, 32'h400, 32'h0);
      chk("oor_lat",  32'(last_lat), 32'd3);
      chk("oor_err",  32'(last_err), 32'd1);
      chk("oor_data", last_rd,       32'd0);

      // Reset after E1 abandons an in-flight store
      access(1'b1, 32'h30, 32'h5A5A_5A5A);
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 32'h30;
      bus.wdata = 32'hAAAA_5555;
      @(posedge clk);
      @(posedge clk);
      #2;
      bus.req = 1'b0;
      rst     = 1'b1;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_ack",  32'(bus.ack),  32'd0);
      chk("midrst_err",  32'(bus.err),  32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      access(1'b0, 32'h30, 32'h0);
      chk("ld30_after_rst", last_rd, 32'h5A5A_5A5A);

      // Fields latched at E0; request held through RESP re-accepts at E0+5
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 32'h40;
      bus.wdata = 32'h0102_0304;
      @(posedge clk);
      first_ack  = 0;
      second_ack = 0;
      n = 0;
      while (second_ack == 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 2) begin
            bus.addr  = 32'h44;
            bus.wdata = 32'hFFFF_FFFF;
         end
         if (n == 5) chk("held_busy_idle", 32'(bus.busy), 32'd1);
         if (n == 5) chk("held_no_ack_idle", 32'(bus.ack), 32'd0);
         if (bus.ack) begin
            if (first_ack == 0) first_ack = n;
            else second_ack = n;
         end
      end
      if (second_ack == 0) chk("held_timeout", 32'(bus.ack), 32'd1);
      bus.req = 1'b0;
      chk("held_first_ack",  32'(first_ack),  32'd4);
      chk("held_second_ack", 32'(second_ack), 32'd9);
      @(negedge clk);
      access(1'b0, 32'h40, 32'h0);
      chk("ld40_data", last_rd, 32'h0102_0304);
      access(1'b0, 32'h44, 32'h0);
      chk("ld44_data", last_rd, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder side of the CPU data-memory interface. Replaces the zero-latency data store with a word-addressed memory that answers after a fixed, parameterised latency.
- Accepts one load/store request at a time from the MEM stage. It holds `busy_o` high as a pipeline-stall request until the access completes, then pulses `ack_o` for one cycle.
- Sits between the EX/MEM pipeline register outputs (address, store data, read/write controls) and the MEM/WB register's read-data input.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; valid byte addresses are 0 to 4*DEPTH_WORDS-4.
- LATENCY, 3, clock edges from request acceptance to response; legal range 1..15.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  request valid; the CPU holds it high, with stable fields, until `ack_o`.
- we_i  input  1  1 = store, 0 = load; sampled at acceptance.
- addr_i  input  32  byte address; sampled at acceptance.
- data_i  input  32  store data; sampled at acceptance.
- busy_o  output  1  stall request to the hazard logic (combinational).
- ack_o  output  1  one-cycle response pulse (registered).
- data_o  output  32  load data (registered); held stable until the next load response.
- err_o  output  1  error flag, valid only while `ack_o` = 1 (registered).

Behaviour:
- Reset (async, any time): state = IDLE, counter = 0, `ack_o` = 0, `err_o` = 0, `data_o` = 0.
  - Memory array is not cleared.
  - An in-flight access is abandoned. A store whose commit edge has not occurred is never written.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If `req_i` = 1 at a rising edge (the acceptance edge, E0):
    - Latch `we_i`, `addr_i`, `data_i` and the error condition.
    - Load counter with LATENCY-1.
    - Go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter != 0: decrement counter and stay in WAIT.
  - If counter = 0: perform the access on the edge EL = E0 + LATENCY, then go to RESP. The access is:
    - Store, no error: `mem[addr[31:2]]` <= latched data.
    - Load, no error: `data_o` <= `mem[addr[31:2]]`.
    - Error: no memory write; `data_o` <= 0.
  - In all three cases, set `ack_o` <= 1 and `err_o` <= error.
- RESP:
  - Lasts exactly one cycle.
  - Next edge: `ack_o` <= 0, `err_o` <= 0, go to IDLE.
  - `req_i` is not sampled in RESP. A following request is accepted no earlier than the first IDLE edge, so the minimum spacing between acceptances is LATENCY+2 edges.
- `busy_o` = (state == IDLE and `req_i`) or (state == WAIT). It is 0 in RESP, so the pipeline advances in the `ack_o` cycle.
- Inputs changing during WAIT have no effect, because all fields are latched at E0.
- Error condition: `addr_i[1:0]` != 0, or `addr_i[31:2]` >= DEPTH_WORDS. An error request completes with normal latency.
- Store acknowledge: `data_o` keeps its previous value.
- Read-after-write: a load accepted after a store's `ack_o` returns the new data.

Test Plan:
- Read latency, LATENCY=3:
  - Stimulus: `req_i`=1, `we_i`=0, `addr_i`=0x10 at E0.
  - Response: `busy_o`=1 from E0 through the cycle before E3; `ack_o`=1 for exactly the cycle after E3; `data_o` = `mem[4]`; `busy_o`=0 in that cycle.
- Store then load:
  - Stimulus: store 0xDEADBEEF to 0x20, wait for `ack_o`, then load 0x20.
  - Response: `data_o`=0xDEADBEEF with `err_o`=0; for the store ack, `data_o` is unchanged.
- Misaligned store:
  - Stimulus: store 0x12345678 to 0x22.
  - Response: `ack_o`=1 and `err_o`=1 after LATENCY edges; a subsequent load of 0x20 returns the old word.
- Out-of-range load:
  - Stimulus: load from 0x400 with DEPTH_WORDS=256.
  - Response: `ack_o`=1, `err_o`=1, `data_o`=0.
- Reset mid-operation:
  - Stimulus: store 0xAAAA5555 to 0x30; assert `rst_i` asynchronously after E1 (LATENCY=3).
  - Response: `busy_o`, `ack_o` and `err_o` go to 0 immediately; a later load of 0x30 returns the pre-store value.
- Fields latched, held request:
  - Stimulus: change `addr_i` and `data_i` during WAIT; keep `req_i` high through RESP.
  - Response: the original address and data are used; no acceptance occurs in RESP; the second acceptance occurs at the IDLE edge, exactly LATENCY+2 edges after E0.
